// File: rtl/sop_pkg.sv
// Shared types and constants for the sequential SOP minterm finder.
// f(a,b,c,d) = ~(a&b) | (c&~d); candidates are ordered with a as the MSB.
package sop_pkg;

    localparam int NVARS   = 4;
    localparam int NCOMBOS = 1 << NVARS;

    // Bit i set means f(i) == 0 (abcd = 12, 13, 15).
    localparam logic [NCOMBOS-1:0] F_ZERO_MINTERMS = 16'b1011_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sop_eval.sv
// Combinational evaluation of the lab function Y = (ab)' + cd'.
// Gate-level form mirrors the structural lab model: NAND, AND with inverted d, OR.
module sop_eval
    import sop_pkg::*;
(
    input  logic [NVARS-1:0] abcd,
    output logic             f
);

    logic a, b, c, d;
    logic nand_ab, c_and_nd;

    assign {a, b, c, d} = abcd;
    assign nand_ab      = ~(a & b);
    assign c_and_nd     = c & ~d;
    assign f            = nand_ab | c_and_nd;

endmodule

// File: rtl/sop_minterm_finder.sv
// Sweeps all 16 input combinations and streams those whose function output
// equals the latched target over a valid/ready port, counting accepted matches.
module sop_minterm_finder #(
    parameter int NVARS = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             target,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [NVARS-1:0] m_abcd,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [NVARS-1:0] LAST_IDX = '1;

    sop_pkg::state_t  state, state_d;
    logic [NVARS-1:0] idx, idx_d;
    logic [NVARS-1:0] abcd_d;
    logic [CNT_W-1:0] cnt_d;
    logic             target_q, target_d;
    logic             f;

    sop_eval u_eval (
        .abcd (idx),
        .f    (f)
    );

    // NOTE: every register gets an explicit async reset value here, so a reset
    // mid-sweep drops any pending output and cannot leave a stale done pulse.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= sop_pkg::IDLE;
            idx         <= '0;
            target_q    <= 1'b0;
            m_abcd      <= '0;
            match_count <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            target_q    <= target_d;
            m_abcd      <= abcd_d;
            match_count <= cnt_d;
        end
    end

    // NOTE: all next-state values default to their current value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        target_d = target_q;
        abcd_d   = m_abcd;
        cnt_d    = match_count;

        unique case (state)
            sop_pkg::IDLE: begin
                if (start) begin
                    target_d = target;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = sop_pkg::SCAN;
                end
            end
            sop_pkg::SCAN: begin
                if (f == target_q) begin
                    abcd_d  = idx;
                    state_d = sop_pkg::OUT;
                end else if (idx == LAST_IDX) begin
                    state_d = sop_pkg::DONE;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            sop_pkg::OUT: begin
                if (m_ready) begin
                    cnt_d = match_count + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = sop_pkg::DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = sop_pkg::SCAN;
                    end
                end
            end
            sop_pkg::DONE: begin
                state_d = sop_pkg::IDLE;
            end
            default: begin
                state_d = sop_pkg::IDLE;
            end
        endcase
    end

    // Output valid is exactly "presenting a match", so it follows the state.
    assign m_valid = (state == sop_pkg::OUT);
    assign busy    = (state != sop_pkg::IDLE);
    assign done    = (state == sop_pkg::DONE);

endmodule

// File: doc/sop_minterm_finder.md
Name: sop_minterm_finder

Overview:
- Sequential inverse of the combinational Y = (ab)' + cd' function block.
- Given a target output value, it sweeps all 16 input combinations {a,b,c,d} and streams every combination whose function output equals the target over a valid/ready interface.
- It also reports the number of matches.
- Used in lab exercises to cross-check truth tables on the FPGA against the structural, dataflow and behavioural models.

Parameters:
- NVARS, 4, number of function inputs; only 4 is supported, kept for the width of the candidate and output buses.
- CNT_W, 5, width of match_count; must hold 2**NVARS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- target  input  1  required function output; latched on an accepted start.
- m_valid  output  1  m_abcd holds a matching combination.
- m_ready  input  1  downstream accepts m_abcd.
- m_abcd  output  NVARS  matching combination, with a in the MSB and d in the LSB.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at the end of a sweep.
- match_count  output  CNT_W  number of accepted matches in the current or last sweep.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep):
  - state=IDLE, idx=0, target_q=0.
  - m_valid=0, m_abcd=0, busy=0, done=0, match_count=0.
  - Any pending output is discarded and no done pulse is produced.
- Function: f(a,b,c,d) = ~(a&b) | (c&~d).
  - f=0 exactly for abcd = 12, 13, 15.
- States:
  - IDLE:
    - If start=1 at the clock edge: target_q<=target, idx<=0, match_count<=0, go to SCAN.
    - Otherwise stay in IDLE.
  - SCAN (one candidate per cycle):
    - If f(idx)==target_q: m_abcd<=idx, m_valid<=1, go to OUT.
    - Else if idx==15: go to DONE.
    - Else: idx<=idx+1.
  - OUT:
    - m_valid and m_abcd stay stable until m_ready=1 at a clock edge; this completes the handshake.
    - On the handshake: m_valid<=0, match_count<=match_count+1.
    - Then if idx==15 go to DONE, else idx<=idx+1 and go to SCAN.
    - m_ready is ignored while m_valid=0.
  - DONE:
    - done=1 for exactly this one cycle; go to IDLE.
    - match_count holds its value until the next accepted start.
- start while busy=1 is ignored; target changes while busy are ignored.
- Holding start high in IDLE relaunches the sweep on the cycle after DONE.
- Latency:
  - First candidate is evaluated in the cycle after start is accepted.
  - A match produces m_valid on the following cycle.
  - With m_ready tied high, a sweep takes 16 + (matches) + 1 cycles, from the start edge to the done cycle inclusive.
- idx is 4 bits and never wraps within a sweep; termination is decided at idx==15.

Decomposition:
- Shared package sop_pkg:
  - state enum: IDLE, SCAN, OUT, DONE.
  - constants NVARS=4 and NCOMBOS=16.
  - function-zero minterm constant 16'b1011_0000_0000_0000 for bench reference.
- One sub-module, sop_eval: purely combinational, NVARS-bit abcd in, f out.
  - It is instantiated on idx and its gate structure matches the lab function.

Test Plan:
- target=0, m_ready=1, single start pulse:
  - m_abcd sequence is 12, 13, 15.
  - match_count=3 at done.
  - done occurs 20 cycles after the start edge.
- target=1, m_ready=1:
  - sequence is 0 to 11, then 14 (13 outputs).
  - match_count=13 and a single done pulse.
- target=0 with m_ready held low for 5 cycles on each output:
  - m_valid and m_abcd stay stable while waiting.
  - no candidate is skipped, and the sequence is still 12, 13, 15.
- start and target toggled during a target=0 sweep:
  - no restart and no change of target.
  - result is 12, 13, 15 with count 3.
- rst asserted while in OUT presenting 13:
  - on the same cycle (asynchronously) m_valid=0, busy=0, match_count=0.
  - after release, a new start with target=0 gives a full 12, 13, 15 sweep.
- start held high across two sweeps with target=1:
  - two consecutive sweeps, each with 13 outputs.
  - match_count is cleared to 0 at the second start and reaches 13 at the second done.
